// File: rtl/vga_timing_pkg.sv
// Shared constants and types for the VGA display path.
// Defaults describe 640x480@60 with a 4:1 pixel-clock divide.
package vga_timing_pkg;

    localparam int unsigned H_ACTIVE_DEF = 640;
    localparam int unsigned H_FP_DEF     = 16;
    localparam int unsigned H_SYNC_DEF   = 96;
    localparam int unsigned H_BP_DEF     = 48;
    localparam int unsigned V_ACTIVE_DEF = 480;
    localparam int unsigned V_FP_DEF     = 10;
    localparam int unsigned V_SYNC_DEF   = 2;
    localparam int unsigned V_BP_DEF     = 33;

    localparam int unsigned H_TOTAL_DEF = H_ACTIVE_DEF + H_FP_DEF + H_SYNC_DEF + H_BP_DEF;
    localparam int unsigned V_TOTAL_DEF = V_ACTIVE_DEF + V_FP_DEF + V_SYNC_DEF + V_BP_DEF;

    typedef struct packed {
        logic h_sync;
        logic v_sync;
        logic de;
        logic line_start;
        logic frame_start;
    } vga_timing_t;

endpackage

// File: rtl/vga_pclk_div.sv
// Pixel-rate clock enable: one clk-wide pulse every CLK_DIV enabled cycles.
// The phase counter freezes while enable is low, so resuming keeps the pixel cadence.
module vga_pclk_div #(
    parameter int unsigned CLK_DIV = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic enable,
    output logic pclk_en
);

    localparam int unsigned DivW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [DivW-1:0] DivMax = DivW'(CLK_DIV - 1);

    logic [DivW-1:0] div_cnt_q, div_cnt_d;
    logic            wrap;

    always_comb begin
        wrap      = (div_cnt_q == DivMax);
        div_cnt_d = div_cnt_q;
        if (enable) begin
            div_cnt_d = wrap ? '0 : div_cnt_q + DivW'(1);
        end
    end

    // Gated by reset so the strobe is low during reset even when CLK_DIV is 1.
    assign pclk_en = enable && !reset && wrap;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            div_cnt_q <= '0;
        end else begin
            div_cnt_q <= div_cnt_d;
        end
    end

endmodule

// File: rtl/vga_timing_gen.sv
// Parametrised VGA raster timing generator with registered, mutually aligned outputs.
// Outputs show the pixel the counters held on the previous pixel tick.
module vga_timing_gen
    import vga_timing_pkg::*;
#(
    parameter int unsigned CLK_DIV  = 4,
    parameter int unsigned H_ACTIVE = H_ACTIVE_DEF,
    parameter int unsigned H_FP     = H_FP_DEF,
    parameter int unsigned H_SYNC   = H_SYNC_DEF,
    parameter int unsigned H_BP     = H_BP_DEF,
    parameter int unsigned V_ACTIVE = V_ACTIVE_DEF,
    parameter int unsigned V_FP     = V_FP_DEF,
    parameter int unsigned V_SYNC   = V_SYNC_DEF,
    parameter int unsigned V_BP     = V_BP_DEF,
    parameter bit          HS_POL   = 1'b0,
    parameter bit          VS_POL   = 1'b0,
    parameter int unsigned CNT_W    = 10
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    output logic             pclk_en,
    output logic             h_sync,
    output logic             v_sync,
    output logic             de,
    output logic [CNT_W-1:0] x_pixel,
    output logic [CNT_W-1:0] y_pixel,
    output logic             line_start,
    output logic             frame_start
);

    localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int unsigned HsStart = H_ACTIVE + H_FP;
    localparam int unsigned HsEnd   = HsStart + H_SYNC;
    localparam int unsigned VsStart = V_ACTIVE + V_FP;
    localparam int unsigned VsEnd   = VsStart + V_SYNC;

    localparam logic [CNT_W-1:0] HMax = CNT_W'(H_TOTAL - 1);
    localparam logic [CNT_W-1:0] VMax = CNT_W'(V_TOTAL - 1);

    localparam vga_timing_t TimingRst = '{
        h_sync:      ~HS_POL,
        v_sync:      ~VS_POL,
        de:          1'b0,
        line_start:  1'b0,
        frame_start: 1'b0
    };

    if (CLK_DIV < 1 || H_ACTIVE < 1 || H_FP < 1 || H_SYNC < 1 || H_BP < 1 ||
        V_ACTIVE < 1 || V_FP < 1 || V_SYNC < 1 || V_BP < 1) begin : gen_bad_interval
        $error("vga_timing_gen: every interval and CLK_DIV must be at least 1");
    end

    if (CNT_W < 1 || CNT_W > 31 || H_TOTAL > (32'd1 << CNT_W) ||
        V_TOTAL > (32'd1 << CNT_W)) begin : gen_bad_width
        $error("vga_timing_gen: CNT_W cannot hold H_TOTAL-1 and V_TOTAL-1");
    end

    logic [CNT_W-1:0] h_cnt_q, h_cnt_d, v_cnt_q, v_cnt_d;
    logic [CNT_W-1:0] x_q, y_q;
    logic [31:0]      h_ext, v_ext;
    vga_timing_t      timing_q, timing_d;

    vga_pclk_div #(
        .CLK_DIV (CLK_DIV)
    ) u_pclk_div (
        .clk     (clk),
        .reset   (reset),
        .enable  (enable),
        .pclk_en (pclk_en)
    );

    always_comb begin
        h_cnt_d = h_cnt_q;
        v_cnt_d = v_cnt_q;
        if (pclk_en) begin
            if (h_cnt_q == HMax) begin
                h_cnt_d = '0;
                v_cnt_d = (v_cnt_q == VMax) ? '0 : v_cnt_q + CNT_W'(1);
            end else begin
                h_cnt_d = h_cnt_q + CNT_W'(1);
            end
        end
    end

    // Decode in 32 bits so sync end points equal to 2**CNT_W cannot alias to zero.
    always_comb begin
        h_ext                = 32'(h_cnt_q);
        v_ext                = 32'(v_cnt_q);
        timing_d             = TimingRst;
        timing_d.h_sync      = (h_ext >= HsStart && h_ext < HsEnd) ? HS_POL : ~HS_POL;
        timing_d.v_sync      = (v_ext >= VsStart && v_ext < VsEnd) ? VS_POL : ~VS_POL;
        timing_d.de          = (h_ext < H_ACTIVE) && (v_ext < V_ACTIVE);
        timing_d.line_start  = (h_cnt_q == '0);
        timing_d.frame_start = (h_cnt_q == '0) && (v_cnt_q == '0);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            h_cnt_q  <= '0;
            v_cnt_q  <= '0;
            x_q      <= '0;
            y_q      <= '0;
            timing_q <= TimingRst;
        end else begin
            h_cnt_q <= h_cnt_d;
            v_cnt_q <= v_cnt_d;
            if (pclk_en) begin
                x_q      <= h_cnt_q;
                y_q      <= v_cnt_q;
                timing_q <= timing_d;
            end
        end
    end

    assign h_sync      = timing_q.h_sync;
    assign v_sync      = timing_q.v_sync;
    assign de          = timing_q.de;
    assign line_start  = timing_q.line_start;
    assign frame_start = timing_q.frame_start;
    assign x_pixel     = x_q;
    assign y_pixel     = y_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench: default 640x480 instance for reset, line and hold timing,
// plus a tiny 8x6 instance for sync polarity, frame period and enable toggling.
module tb_vga_timing_gen;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0d expected=%0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Default instance
    logic       rst = 1'b1, en = 1'b1;
    logic       pclk_en, h_sync, v_sync, de, line_start, frame_start;
    logic [9:0] x_pixel, y_pixel;

    vga_timing_gen u_dut (
        .clk         (clk),
        .reset       (rst),
        .enable      (en),
        .pclk_en     (pclk_en),
        .h_sync      (h_sync),
        .v_sync      (v_sync),
        .de          (de),
        .x_pixel     (x_pixel),
        .y_pixel     (y_pixel),
        .line_start  (line_start),
        .frame_start (frame_start)
    );

    // Small instance: H 4/1/2/1, V 3/1/1/1, active-high syncs, one clk per pixel
    logic       rst_s = 1'b1, en_s = 1'b1;
    logic       pclk_en_s, h_sync_s, v_sync_s, de_s, line_start_s, frame_start_s;
    logic [9:0] x_s, y_s;

    vga_timing_gen #(
        .CLK_DIV  (1),
        .H_ACTIVE (4),
        .H_FP     (1),
        .H_SYNC   (2),
        .H_BP     (1),
        .V_ACTIVE (3),
        .V_FP     (1),
        .V_SYNC   (1),
        .V_BP     (1),
        .HS_POL   (1'b1),
        .VS_POL   (1'b1),
        .CNT_W    (10)
    ) u_dut_s (
        .clk         (clk),
        .reset       (rst_s),
        .enable      (en_s),
        .pclk_en     (pclk_en_s),
        .h_sync      (h_sync_s),
        .v_sync      (v_sync_s),
        .de          (de_s),
        .x_pixel     (x_s),
        .y_pixel     (y_s),
        .line_start  (line_start_s),
        .frame_start (frame_start_s)
    );

    function automatic logic [31:0] small_exp(input int p);
        int x, y;
        x = p % 8;
        y = (p / 8) % 6;
        return 32'({10'(x), 10'(y), (x >= 5 && x <= 6), (y == 4), (x < 4 && y < 3),
                    (x == 0), (x == 0 && y == 0)});
    endfunction

    function automatic logic [31:0] small_obs();
        return 32'({x_s, y_s, h_sync_s, v_sync_s, de_s, line_start_s, frame_start_s});
    endfunction

    task automatic check_reset_vals(input string tag);
        check({tag, " pclk_en"}, 32'(pclk_en), 0);
        check({tag, " h_sync"}, 32'(h_sync), 1);
        check({tag, " v_sync"}, 32'(v_sync), 1);
        check({tag, " de"}, 32'(de), 0);
        check({tag, " x"}, 32'(x_pixel), 0);
        check({tag, " y"}, 32'(y_pixel), 0);
        check({tag, " strobes"}, 32'({line_start, frame_start}), 0);
    endtask

    // Release reset just after an edge; pclk_en must appear in cycle 4, pixel (0,0) after it.
    task automatic first_pixel_seq(input string tag);
        tick();
        rst = 1'b0;
        #1;
        check({tag, " pclk c1"}, 32'(pclk_en), 0);
        tick();
        check({tag, " pclk c2"}, 32'(pclk_en), 0);
        tick();
        check({tag, " pclk c3"}, 32'(pclk_en), 0);
        tick();
        check({tag, " pclk c4"}, 32'(pclk_en), 1);
        check({tag, " de before first tick"}, 32'(de), 0);
        tick();
        check({tag, " first pixel de/ls/fs"}, 32'({de, line_start, frame_start}), 32'b111);
        check({tag, " first pixel xy"}, 32'({x_pixel, y_pixel}), 0);
    endtask

    initial begin
        int hs_low, de_hi, ls_hi, xmax, hs_min, hs_max, xchg, de_bad, frz_bad, waited;
        int fs_first, fs_second;
        logic [9:0]  xprev;
        logic [31:0] snap;

        // Reset values of both instances
        tick();
        tick();
        check_reset_vals("reset");
        check("reset small syncs", 32'({h_sync_s, v_sync_s}), 0);
        check("reset small pclk_en", 32'(pclk_en_s), 0);

        first_pixel_seq("rel1");

        // One full line of 800 ticks = 3200 clk, starting from pixel (0,0)
        hs_low = 0; de_hi = 0; ls_hi = 0; xmax = 0; hs_min = 9999; hs_max = 0;
        xchg = 0; de_bad = 0;
        xprev = '0;
        for (int k = 0; k < 3200; k++) begin
            if (k > 0) begin
                tick();
                if (x_pixel != xprev) xchg++;
            end
            xprev = x_pixel;
            if (!h_sync) begin
                hs_low++;
                if (int'(x_pixel) < hs_min) hs_min = int'(x_pixel);
                if (int'(x_pixel) > hs_max) hs_max = int'(x_pixel);
            end
            if (de) de_hi++;
            if (de != (x_pixel < 10'd640)) de_bad++;
            if (line_start) ls_hi++;
            if (int'(x_pixel) > xmax) xmax = int'(x_pixel);
        end
        check("hsync low clk", 32'(hs_low), 384);
        check("hsync first x", 32'(hs_min), 656);
        check("hsync last x", 32'(hs_max), 751);
        check("de high clk", 32'(de_hi), 2560);
        check("de vs x", 32'(de_bad), 0);
        check("line_start width clk", 32'(ls_hi), 4);
        check("x max", 32'(xmax), 799);
        check("x steps per line", 32'(xchg), 799);
        tick();
        check("line 1 start", 32'({x_pixel, y_pixel, line_start, frame_start}),
              32'({10'd0, 10'd1, 1'b1, 1'b0}));
        check("vsync idle on line 1", 32'(v_sync), 1);

        // Hold for 37 clk at x=100, one clk into that pixel (divider phase 1)
        waited = 0;
        while (x_pixel != 10'd100 && waited < 1000) begin
            tick();
            waited++;
        end
        check("reach x=100", 32'(x_pixel), 100);
        tick();
        en = 1'b0;
        snap = 32'({x_pixel, y_pixel, h_sync, v_sync, de, line_start, frame_start});
        frz_bad = 0;
        for (int i = 0; i < 37; i++) begin
            tick();
            if (pclk_en) frz_bad++;
            if (32'({x_pixel, y_pixel, h_sync, v_sync, de, line_start, frame_start}) != snap)
                frz_bad++;
        end
        check("hold frozen", 32'(frz_bad), 0);
        check("hold x", 32'(x_pixel), 100);
        en = 1'b1;
        #1;
        check("resume pclk c1", 32'(pclk_en), 0);
        tick();
        check("resume pclk c2", 32'(pclk_en), 0);
        tick();
        check("resume pclk c3", 32'(pclk_en), 1);
        check("resume x before tick", 32'(x_pixel), 100);
        tick();
        check("resume x next", 32'(x_pixel), 101);

        // Asynchronous reset mid-line, seen within the same cycle
        rst = 1'b1;
        #1;
        check_reset_vals("midreset");
        tick();
        first_pixel_seq("rel2");

        // Small instance: two full frames against the model
        tick();
        rst_s = 1'b0;
        fs_first = -1;
        fs_second = -1;
        for (int k = 1; k <= 96; k++) begin
            tick();
            check("small raster", small_obs(), small_exp(k - 1));
            if (frame_start_s) begin
                if (fs_first < 0) fs_first = k;
                else if (fs_second < 0) fs_second = k;
            end
        end
        check("small frame period clk", 32'(fs_second - fs_first), 48);

        // Enable toggling every other clk: one raster step per high cycle
        for (int i = 0; i < 10; i++) begin
            en_s = 1'b0;
            #1;
            check("toggle pclk low", 32'(pclk_en_s), 0);
            tick();
            check("toggle hold", small_obs(), small_exp(95 + i));
            en_s = 1'b1;
            tick();
            check("toggle step", small_obs(), small_exp(96 + i));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
